// File: rtl/sobel_threshold_stream.sv
// Two-stage valid/ready pipeline: sums signed Sobel channels, takes |sum|, thresholds to a binary pixel.
// Optional per-frame white-pixel counter enabled by defining SOBEL_THRESHOLD_STATS_EN.
module sobel_threshold_stream #(
   parameter int DATA_WIDTH        = 10,
   parameter int NUM_CHANNELS      = 3,
   parameter int OUT_WIDTH         = 8,
   parameter int SUM_WIDTH         = DATA_WIDTH + $clog2(NUM_CHANNELS) + 1,
   parameter int DEFAULT_THRESHOLD = 0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [SUM_WIDTH-1:0]               threshold_in,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
   input  logic                               in_sof,
   input  logic                               in_eof,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [OUT_WIDTH-1:0]               out_data,
   output logic                               out_sof,
`ifdef SOBEL_THRESHOLD_STATS_EN
   output logic [31:0]                        edge_count,
   output logic                               edge_count_valid,
`endif
   output logic                               out_eof
);

   logic [SUM_WIDTH-1:0] ext [NUM_CHANNELS];
   logic [SUM_WIDTH-1:0] sum_next;
   logic [SUM_WIDTH-1:0] beat_thr;

   logic                 s1_valid_reg;
   logic [SUM_WIDTH-1:0] s1_sum_reg;
   logic                 s1_sof_reg;
   logic                 s1_eof_reg;
   logic [SUM_WIDTH-1:0] s1_thr_reg;
   logic [SUM_WIDTH-1:0] thr_reg;

   logic                 out_valid_reg;
   logic [OUT_WIDTH-1:0] out_data_reg;
   logic                 out_sof_reg;
   logic                 out_eof_reg;

   logic                 s2_ready;
   logic [SUM_WIDTH-1:0] mag;
   logic                 s2_white;

   // Sign bits are replicated by hand so the adder can stay plain unsigned bit-vector arithmetic.
   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ext
         assign ext[gi] = {{(SUM_WIDTH-DATA_WIDTH){in_data[gi*DATA_WIDTH+DATA_WIDTH-1]}},
                           in_data[gi*DATA_WIDTH +: DATA_WIDTH]};
      end
   endgenerate

   always_comb begin
      sum_next = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         sum_next = sum_next + ext[i];
      end
   end

   assign beat_thr = in_sof ? threshold_in : thr_reg;
   assign s2_ready = !out_valid_reg || out_ready;
   assign in_ready = !s1_valid_reg || s2_ready;

   // SUM_WIDTH has one spare bit, so even the most negative sum negates into range as unsigned.
   assign mag      = s1_sum_reg[SUM_WIDTH-1] ? (~s1_sum_reg + SUM_WIDTH'(1)) : s1_sum_reg;
   assign s2_white = (mag > s1_thr_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg  <= 1'b0;
         s1_sum_reg    <= '0;
         s1_sof_reg    <= 1'b0;
         s1_eof_reg    <= 1'b0;
         s1_thr_reg    <= '0;
         thr_reg       <= SUM_WIDTH'(DEFAULT_THRESHOLD);
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sof_reg   <= 1'b0;
         out_eof_reg   <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
               s1_sum_reg <= sum_next;
               s1_sof_reg <= in_sof;
               s1_eof_reg <= in_eof;
               s1_thr_reg <= beat_thr;
               if (in_sof) begin
                  thr_reg <= threshold_in;
               end
            end
         end
         if (s2_ready) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               out_data_reg <= s2_white ? '1 : '0;
               out_sof_reg  <= s1_sof_reg;
               out_eof_reg  <= s1_eof_reg;
            end
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sof   = out_sof_reg;
   assign out_eof   = out_eof_reg;

`ifdef SOBEL_THRESHOLD_STATS_EN
   logic        out_fire;
   logic [31:0] cnt_reg;
   logic [31:0] cnt_base;
   logic [31:0] cnt_next;
   logic [31:0] edge_count_reg;
   logic        edge_count_valid_reg;

   assign out_fire = out_valid_reg && out_ready;

   always_comb begin
      cnt_base = out_sof_reg ? 32'd0 : cnt_reg;
      cnt_next = cnt_base;
      if (out_data_reg[0] && (cnt_base != 32'hFFFF_FFFF)) begin
         cnt_next = cnt_base + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg              <= '0;
         edge_count_reg       <= '0;
         edge_count_valid_reg <= 1'b0;
      end else begin
         edge_count_valid_reg <= 1'b0;
         if (out_fire) begin
            cnt_reg <= cnt_next;
            if (out_eof_reg) begin
               edge_count_reg       <= cnt_next;
               edge_count_valid_reg <= 1'b1;
            end
         end
      end
   end

   assign edge_count       = edge_count_reg;
   assign edge_count_valid = edge_count_valid_reg;
`endif

endmodule

// File: tb/tb_sobel_threshold_stream.sv
// Directed bench for sobel_threshold_stream: queued beats with hand-computed expected pixels.
// Handshake, stall stability and in_ready are checked on every cycle of the driver.
module tb_sobel_threshold_stream;

   typedef struct {
      logic [29:0] d;
      logic        sof;
      logic        eof;
      logic [11:0] thr;
   } beat_t;

   typedef struct {
      logic [7:0] d;
      logic       sof;
      logic       eof;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] threshold_in;
   logic        in_valid;
   logic        in_ready;
   logic [29:0] in_data;
   logic        in_sof;
   logic        in_eof;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_sof;
   logic        out_eof;
`ifdef SOBEL_THRESHOLD_STATS_EN
   logic [31:0] edge_count;
   logic        edge_count_valid;
   int          tb_cnt = 0;
   int          ec_exp = 0;
   bit          pulse_exp = 1'b0;
`endif

   int          checks = 0;
   int          errors = 0;
   int          occ = 0;
   bit          stalled = 1'b0;
   logic [7:0]  held_d;
   logic [1:0]  held_f;
   beat_t       in_q[$];
   exp_t        exp_q[$];
   bit          rdy_q[$];

   sobel_threshold_stream dut (
      .clk              (clk),
      .reset            (reset),
      .threshold_in     (threshold_in),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .in_sof           (in_sof),
      .in_eof           (in_eof),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_sof          (out_sof),
`ifdef SOBEL_THRESHOLD_STATS_EN
      .edge_count       (edge_count),
      .edge_count_valid (edge_count_valid),
`endif
      .out_eof          (out_eof)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [29:0] pk(input int a, input int b, input int c);
      logic [31:0] ta, tb, tc;
      ta = a;
      tb = b;
      tc = c;
      return {tc[9:0], tb[9:0], ta[9:0]};
   endfunction

   task automatic push_in(input int a, input int b, input int c, input bit sof, input bit eof, input int thr);
      beat_t bt;
      bt.d   = pk(a, b, c);
      bt.sof = sof;
      bt.eof = eof;
      bt.thr = 12'(thr);
      in_q.push_back(bt);
   endtask

   task automatic push(input int a, input int b, input int c, input bit sof, input bit eof,
                       input int thr, input logic [7:0] ed);
      exp_t e;
      push_in(a, b, c, sof, eof, thr);
      e.d   = ed;
      e.sof = sof;
      e.eof = eof;
      exp_q.push_back(e);
   endtask

   // One cycle: drive at the negedge, check at negedge+1, update the model, wait for the next negedge.
   task automatic step();
      exp_t  e;
      beat_t bt;
      bit    o_fire, i_fire;
      if (rdy_q.size() > 0) out_ready = rdy_q.pop_front();
      else                  out_ready = 1'b1;
      if (in_q.size() > 0) begin
         in_valid     = 1'b1;
         in_data      = in_q[0].d;
         in_sof       = in_q[0].sof;
         in_eof       = in_q[0].eof;
         threshold_in = in_q[0].thr;
      end else begin
         in_valid = 1'b0;
         in_sof   = 1'b0;
         in_eof   = 1'b0;
      end
      #1;
      if (stalled) begin
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_data", {24'b0, out_data}, {24'b0, held_d});
         chk("hold_flags", {30'b0, out_sof, out_eof}, {30'b0, held_f});
      end
      chk("in_ready", {31'b0, in_ready}, {31'b0, ((occ < 2) || out_ready)});
`ifdef SOBEL_THRESHOLD_STATS_EN
      chk("edge_count_valid", {31'b0, edge_count_valid}, {31'b0, pulse_exp});
      if (pulse_exp) chk("edge_count", edge_count, ec_exp);
      pulse_exp = 1'b0;
`endif
      o_fire = out_valid && out_ready;
      i_fire = in_valid && in_ready;
      if (o_fire) begin
         if (exp_q.size() == 0) begin
            chk("out_unexpected", {31'b0, o_fire}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", {24'b0, out_data}, {24'b0, e.d});
            chk("out_sof", {31'b0, out_sof}, {31'b0, e.sof});
            chk("out_eof", {31'b0, out_eof}, {31'b0, e.eof});
`ifdef SOBEL_THRESHOLD_STATS_EN
            if (e.sof) tb_cnt = 0;
            if (e.d == 8'hFF) tb_cnt++;
            if (e.eof) begin
               pulse_exp = 1'b1;
               ec_exp    = tb_cnt;
            end
`endif
         end
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_f  = {out_sof, out_eof};
      if (i_fire) bt = in_q.pop_front();
      occ = occ + int'(i_fire) - int'(o_fire);
      @(negedge clk);
   endtask

   task automatic run(input int budget);
      int cyc = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         step();
         cyc++;
      end
      step();
      chk("drain_timeout", in_q.size() + exp_q.size(), 32'd0);
   endtask

   initial begin
      bit pat[12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0};
      reset        = 1'b1;
      threshold_in = '0;
      in_valid     = 1'b0;
      in_data      = '0;
      in_sof       = 1'b0;
      in_eof       = 1'b0;
      out_ready    = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", {24'b0, out_data}, 32'd0);
      chk("rst_out_flags", {30'b0, out_sof, out_eof}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef SOBEL_THRESHOLD_STATS_EN
      chk("rst_edge_count", edge_count, 32'd0);
      chk("rst_edge_count_valid", {31'b0, edge_count_valid}, 32'd0);
`endif
      @(negedge clk);

      // Basic thresholds and two-edge latency; threshold_in=0 on the eof beat must be ignored.
      push(40, 30, 31, 1, 0, 100, 8'hFF);
      step();
      chk("latency_edge1", {31'b0, out_valid}, 32'd0);
      push(40, 30, 30, 0, 1, 0, 8'h00);
      step();
      chk("latency_edge2", {31'b0, out_valid}, 32'd1);
      run(20);

      // Negative sums, extremes, single-pixel frames.
      push(-512, -512, -512, 1, 1, 1535, 8'hFF);
      push(-50, -30, -20, 1, 0, 100, 8'h00);
      push(-50, -30, -21, 0, 1, 0, 8'hFF);
      push(511, 511, 511, 1, 1, 1532, 8'hFF);
      push(511, 511, 511, 1, 1, 1533, 8'h00);
      push(-512, -512, -512, 1, 1, 1536, 8'h00);
      run(40);

      // Per-frame threshold with mid-frame threshold_in changes.
      push(5, 3, 2, 1, 0, 10, 8'h00);
      push(5, 3, 3, 0, 0, 200, 8'hFF);
      push(0, 0, -11, 0, 1, 0, 8'hFF);
      push(100, 100, 0, 1, 0, 200, 8'h00);
      push(100, 100, 1, 0, 0, 5, 8'hFF);
      push(-100, -50, -49, 0, 1, 5, 8'h00);
      run(40);

      // Backpressure with an irregular out_ready pattern.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 12; i++) rdy_q.push_back(pat[i]);
      end
      push(30, 0, 0, 1, 0, 25, 8'hFF);
      push(10, 0, 0, 0, 0, 0, 8'h00);
      push(40, 0, 0, 0, 0, 0, 8'hFF);
      push(0, 0, 0, 0, 0, 0, 8'h00);
      push(-60, 0, 0, 0, 0, 0, 8'hFF);
      push(20, 0, 0, 0, 0, 0, 8'h00);
      push(70, 0, 0, 0, 0, 0, 8'hFF);
      push(-5, 0, 0, 0, 1, 0, 8'h00);
      run(60);
      rdy_q.delete();

      // Reset with two beats in flight; threshold 300 must be forgotten.
      rdy_q.push_back(1'b0);
      rdy_q.push_back(1'b0);
      push_in(400, 0, 0, 1, 0, 300);
      push_in(500, 0, 0, 0, 0, 300);
      step();
      step();
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      occ     = 0;
      stalled = 1'b0;
      exp_q.delete();
      rdy_q.delete();
`ifdef SOBEL_THRESHOLD_STATS_EN
      tb_cnt    = 0;
      pulse_exp = 1'b0;
`endif
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_out_data", {24'b0, out_data}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      push(1, 0, 0, 0, 0, 300, 8'hFF);
      push(0, 0, 0, 0, 1, 300, 8'h00);
      push(3, 3, 0, 1, 1, 5, 8'hFF);
      run(30);

`ifdef SOBEL_THRESHOLD_STATS_EN
      push(20, 0, 0, 1, 0, 10, 8'hFF);
      push(5, 0, 0, 0, 0, 0, 8'h00);
      push(30, 0, 0, 0, 0, 0, 8'hFF);
      push(11, 0, 0, 0, 0, 0, 8'hFF);
      push(10, 0, 0, 0, 1, 0, 8'h00);
      run(30);
      chk("frame_count_a", edge_count, 32'd3);
      push(20, 0, 0, 1, 0, 10, 8'hFF);
      push(0, 0, 0, 0, 1, 0, 8'h00);
      run(30);
      chk("frame_count_b", edge_count, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
